// File: rtl/tdc_thermo_decoder.sv
// Thermometer-code TDC reader: pipelined popcount, windowed accumulation, valid/ready result port.
// Optional build macro TDC_BUBBLE_FILTER_EN enables a 3-tap majority bubble filter ahead of S0.

module tdc_popcnt_group #(
  parameter int GROUP = 16,
  parameter int GW    = $clog2(GROUP + 1)
)(
  input  logic             clk,
  input  logic             clrn,
  input  logic [GROUP-1:0] bits,
  output logic [GW-1:0]    cnt
);
  logic [GW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < GROUP; i++) sum = sum + GW'(bits[i]);
  end

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) cnt <= '0;
    else       cnt <= sum;
endmodule

module tdc_thermo_decoder #(
  parameter  int N        = 128,
  parameter  int GROUP    = 16,
  parameter  int AVG_LOG2 = 4,
  localparam int CW       = $clog2(N + 1),
  localparam int AW       = CW + AVG_LOG2
)(
  input  logic          clk,
  input  logic          clrn,
  input  logic [N-1:0]  thermo,
  input  logic          in_valid,
  input  logic          flush,
  output logic [CW-1:0] last_count,
  output logic [AW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun
);
  localparam int NG     = N / GROUP;
  localparam int GW     = $clog2(GROUP + 1);
  localparam int SW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int STAGES = 2;

  logic [N-1:0] thermo_f;
`ifdef TDC_BUBBLE_FILTER_EN
  // Neighbours beyond the chain ends read as 1 below bit 0 and 0 above bit N-1.
  logic [N-1:0] t_lo, t_hi;
  assign t_lo     = {thermo[N-2:0], 1'b1};
  assign t_hi     = {1'b0, thermo[N-1:1]};
  assign thermo_f = (t_lo & thermo) | (thermo & t_hi) | (t_lo & t_hi);
`else
  assign thermo_f = thermo;
`endif

  logic [STAGES:0]          vld_pipe;
  logic [N-1:0]             s0_thermo;
  logic [NG-1:0][GW-1:0]    part;
  logic [CW-1:0]            part_sum;

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      vld_pipe  <= '0;
      s0_thermo <= '0;
    end else begin
      if (in_valid) s0_thermo <= thermo_f;
      if (flush) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    tdc_popcnt_group #(.GROUP(GROUP), .GW(GW)) u_grp (
      .clk  (clk),
      .clrn (clrn),
      .bits (s0_thermo[g*GROUP +: GROUP]),
      .cnt  (part[g])
    );
  end

  always_comb begin
    part_sum = '0;
    for (int g = 0; g < NG; g++) part_sum = part_sum + CW'(part[g]);
  end

  // last_count doubles as the S2 count register feeding the accumulator.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn)                        last_count <= '0;
    else if (vld_pipe[1] && !flush)   last_count <= part_sum;

  logic [SW-1:0] smp_cnt;
  logic [AW-1:0] acc, win_sum;
  logic          win_done;

  assign win_sum  = acc + AW'(last_count);
  assign win_done = vld_pipe[STAGES] && (smp_cnt == SW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      smp_cnt <= '0;
      acc     <= '0;
    end else if (flush) begin
      smp_cnt <= '0;
      acc     <= '0;
    end else if (vld_pipe[STAGES]) begin
      if (win_done) begin
        smp_cnt <= '0;
        acc     <= '0;
      end else begin
        smp_cnt <= smp_cnt + SW'(1);
        acc     <= win_sum;
      end
    end

  // A completing window may reuse the slot being drained on the same edge.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (win_done) begin
      if (!out_valid || out_ready) begin
        out_data  <= win_sum;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule
